// File: rtl/booth_seq_mult.sv
// Iterative radix-4 Booth multiplier that retires one Booth digit per clock into a shifting accumulator.
// Define BOOTH_SIGNED_EN to honour is_signed; otherwise every operation is unsigned.
module booth_seq_mult #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int HW = WIDTH + 2;
    localparam int AW = 2 * WIDTH + 2;
    localparam int BW = WIDTH + 3;
    localparam int NU = WIDTH / 2 + 1;
    localparam int CW = $clog2(NU + 1);
    localparam logic [CW-1:0] LAST_U = CW'(NU - 1);
    localparam logic [CW-1:0] LAST_S = CW'(NU - 2);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [HW-1:0]        mcand_q, mcand_d;
    logic [BW-1:0]        mplier_q, mplier_d;
    logic                 mode_q, mode_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [AW-1:0]        acc_q, acc_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 out_valid_q, out_valid_d;
    logic                 busy_q, busy_d;

    logic                 mode_in;
    logic                 accept;
    logic [2:0]           window;
    logic                 pp_neg;
    logic                 pp_two;
    logic                 pp_zero;
    logic [HW-1:0]        pp_mag;
    logic [HW-1:0]        pp;
    logic [HW-1:0]        upper_sum;
    logic [AW-1:0]        acc_shift;
    logic [AW-1:0]        acc_hold;
    logic [AW-1:0]        acc_step;
    logic                 last_digit;

`ifdef BOOTH_SIGNED_EN
    assign mode_in = is_signed;
`else
    logic unused_is_signed;
    assign unused_is_signed = is_signed;
    assign mode_in = 1'b0;
`endif

    assign in_ready = rst_n & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
    assign accept   = in_valid & in_ready;

    // The multiplier register shifts right by two every digit, so the window is always its low bits.
    always_comb begin
        window  = mplier_q[2:0];
        pp_neg  = window[2] & ~(window[1] & window[0]);
        pp_two  = (window == 3'b011) | (window == 3'b100);
        pp_zero = (window == 3'b000) | (window == 3'b111);
        if (pp_zero) begin
            pp_mag = '0;
        end else if (pp_two) begin
            pp_mag = {mcand_q[HW-2:0], 1'b0};
        end else begin
            pp_mag = mcand_q;
        end
        pp         = pp_neg ? ~pp_mag : pp_mag;
        upper_sum  = acc_q[AW-1:WIDTH] + pp + HW'(pp_neg);
        acc_shift  = {{2{upper_sum[HW-1]}}, upper_sum, acc_q[WIDTH-1:2]};
        acc_hold   = {upper_sum, acc_q[WIDTH-1:0]};
        last_digit = (cnt_q == (mode_q ? LAST_S : LAST_U));
        // Unsigned mode has one extra digit; skipping its shift keeps the product aligned to bit 0.
        acc_step   = (last_digit && !mode_q) ? acc_hold : acc_shift;
    end

    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        mode_d      = mode_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        product_d   = product_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            CALC: begin
                acc_d    = acc_step;
                mplier_d = {2'b00, mplier_q[BW-1:2]};
                if (last_digit) begin
                    state_d     = DONE;
                    product_d   = acc_step[2*WIDTH-1:0];
                    out_valid_d = 1'b1;
                    busy_d      = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new operation may start from IDLE or overlap the DONE cycle being drained.
        if (accept) begin
            state_d  = CALC;
            mode_d   = mode_in;
            mcand_d  = mode_in ? {{2{multiplicand[WIDTH-1]}}, multiplicand}
                               : {2'b00, multiplicand};
            mplier_d = {(mode_in ? {2{multiplier[WIDTH-1]}} : 2'b00), multiplier, 1'b0};
            cnt_d    = '0;
            acc_d    = '0;
            busy_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mcand_q     <= '0;
            mplier_q    <= '0;
            mode_q      <= 1'b0;
            cnt_q       <= '0;
            acc_q       <= '0;
            product_q   <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            mode_q      <= mode_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            product_q   <= product_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign product   = product_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule
